// File: rtl/ste_avg_pkg.sv
// ============================================================================
// Module      : ste_avg_pkg
// Description : Shared width, rounding and extension helpers for the ste
//               moving-average filter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ste_avg_pkg;

  // Widest extension ever needed: 32-bit data plus a 1024-deep window.
  localparam int EXT_W = 42;

  function automatic int acc_width(input int data_w, input int log2_taps);
    return data_w + log2_taps;
  endfunction

  function automatic int rnd_const(input int log2_taps, input bit round);
    return round ? (1 << (log2_taps - 1)) : 0;
  endfunction

  function automatic logic [EXT_W-1:0] ext(input logic [31:0] v, input int w, input bit sgn);
    logic [EXT_W-1:0] r;
    r = '0;
    for (int i = 0; i < EXT_W; i++) begin
      if (i < w)
        r[i] = v[i];
      else if (sgn)
        r[i] = v[w-1];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ste_avg_ring.sv
// ============================================================================
// Module      : ste_avg_ring
// Description : Circular sample window with write pointer, saturating fill
//               count and oldest-sample read port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ste_avg_ring
  import ste_avg_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int LOG2_TAPS = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_we,
  input  logic                 i_clr,
  input  logic [DATA_W-1:0]    i_din,
  output logic [DATA_W-1:0]    o_oldest,
  output logic [LOG2_TAPS:0]   o_fill_cnt,
  output logic                 o_full
);

  localparam int               C_TAPS   = 1 << LOG2_TAPS;
  localparam logic [LOG2_TAPS:0] C_TAPS_V = (LOG2_TAPS + 1)'(C_TAPS);

  logic [DATA_W-1:0]    r_mem [C_TAPS];
  logic [LOG2_TAPS-1:0] r_wr_ptr;
  logic [LOG2_TAPS:0]   r_fill;
  logic                 w_wr;

  assign w_wr = i_we & ~i_clr;

  // Storage carries no reset so it maps onto RAM; stale words are masked by fill.
  always_ff @(posedge clk) begin
    if (w_wr)
      r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
    end else if (w_wr) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (r_fill != C_TAPS_V)
        r_fill <= r_fill + 1'b1;
    end
  end

  assign o_full     = (r_fill == C_TAPS_V);
  assign o_fill_cnt = r_fill;
  assign o_oldest   = o_full ? r_mem[r_wr_ptr] : '0;

endmodule

`default_nettype wire

// File: rtl/ste_avg_mavg.sv
// ============================================================================
// Module      : ste_avg_mavg
// Description : Power-of-two moving-average filter using a running sum over
//               a circular window, signed/unsigned with optional rounding.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ste_avg_mavg
  import ste_avg_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int LOG2_TAPS = 3,
  parameter int SIGNED    = 0,
  parameter int ROUND     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_W-1:0]    din_i,
  input  logic                 din_update_i,
  input  logic                 avg_clr_i,
  output logic [DATA_W-1:0]    dout_o,
  output logic                 dout_update_o,
  output logic                 dout_full_o,
  output logic [LOG2_TAPS:0]   fill_cnt_o
);

  localparam int               ACC_W = acc_width(DATA_W, LOG2_TAPS);
  localparam logic [ACC_W-1:0] C_RND = ACC_W'(rnd_const(LOG2_TAPS, ROUND != 0));

  logic [DATA_W-1:0] w_oldest;
  logic [ACC_W-1:0]  w_din_ext;
  logic [ACC_W-1:0]  w_old_ext;
  logic [ACC_W-1:0]  w_acc_next;
  logic [ACC_W-1:0]  w_sum_rnd;
  logic [DATA_W-1:0] w_avg;
  logic [ACC_W-1:0]  r_acc;
  logic [DATA_W-1:0] r_dout;
  logic              r_upd;

  ste_avg_ring #(
    .DATA_W    (DATA_W),
    .LOG2_TAPS (LOG2_TAPS)
  ) u_ring (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we       (din_update_i),
    .i_clr      (avg_clr_i),
    .i_din      (din_i),
    .o_oldest   (w_oldest),
    .o_fill_cnt (fill_cnt_o),
    .o_full     (dout_full_o)
  );

  assign w_din_ext  = ACC_W'(ext(32'(din_i), DATA_W, SIGNED != 0));
  assign w_old_ext  = ACC_W'(ext(32'(w_oldest), DATA_W, SIGNED != 0));
  // The accumulator is wide enough for a full window of extremes; no overflow.
  assign w_acc_next = r_acc + w_din_ext - w_old_ext;
  assign w_sum_rnd  = w_acc_next + C_RND;

  generate
    if (SIGNED != 0) begin : g_signed_shift
      assign w_avg = DATA_W'($signed(w_sum_rnd) >>> LOG2_TAPS);
    end else begin : g_unsigned_shift
      assign w_avg = DATA_W'(w_sum_rnd >> LOG2_TAPS);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_dout <= '0;
      r_upd  <= 1'b0;
    end else if (avg_clr_i) begin
      r_acc  <= '0;
      r_dout <= '0;
      r_upd  <= 1'b0;
    end else if (din_update_i) begin
      r_acc  <= w_acc_next;
      r_dout <= w_avg;
      r_upd  <= 1'b1;
    end else begin
      r_upd  <= 1'b0;
    end
  end

  assign dout_o        = r_dout;
  assign dout_update_o = r_upd;

endmodule

`default_nettype wire

// File: tb/tb_ste_avg_mavg.sv
// ============================================================================
// Module      : tb_ste_avg_mavg
// Description : Directed and window-model checks of the moving-average filter
//               across several parameter sets sharing one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ste_avg_mavg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din;
  logic        upd;
  logic        clr;

  logic [15:0] dout_d, dout_r, dout_s, dout_sr;
  logic        upd_d, upd_r, upd_s, upd_sr;
  logic        full_d, full_r, full_s, full_sr;
  logic [3:0]  fill_d, fill_r, fill_s, fill_sr;
  logic [7:0]  dout_1;
  logic        upd_1, full_1;
  logic [1:0]  fill_1;
  logic [11:0] dout_6;
  logic        upd_6, full_6;
  logic [6:0]  fill_6;

  int total = 0;
  int bad   = 0;
  int hist [64];
  int n     = 0;
  int cnt   = 0;
  bit exp_upd = 1'b0;

  always #5 clk = ~clk;

  ste_avg_mavg u_d (.clk(clk), .rst_n(rst_n), .din_i(din), .din_update_i(upd), .avg_clr_i(clr),
                    .dout_o(dout_d), .dout_update_o(upd_d), .dout_full_o(full_d), .fill_cnt_o(fill_d));
  ste_avg_mavg #(.DATA_W(16), .LOG2_TAPS(3), .SIGNED(0), .ROUND(1)) u_r (.clk(clk), .rst_n(rst_n),
                    .din_i(din), .din_update_i(upd), .avg_clr_i(clr), .dout_o(dout_r),
                    .dout_update_o(upd_r), .dout_full_o(full_r), .fill_cnt_o(fill_r));
  ste_avg_mavg #(.DATA_W(16), .LOG2_TAPS(3), .SIGNED(1), .ROUND(0)) u_s (.clk(clk), .rst_n(rst_n),
                    .din_i(din), .din_update_i(upd), .avg_clr_i(clr), .dout_o(dout_s),
                    .dout_update_o(upd_s), .dout_full_o(full_s), .fill_cnt_o(fill_s));
  ste_avg_mavg #(.DATA_W(16), .LOG2_TAPS(3), .SIGNED(1), .ROUND(1)) u_sr (.clk(clk), .rst_n(rst_n),
                    .din_i(din), .din_update_i(upd), .avg_clr_i(clr), .dout_o(dout_sr),
                    .dout_update_o(upd_sr), .dout_full_o(full_sr), .fill_cnt_o(fill_sr));
  ste_avg_mavg #(.DATA_W(8), .LOG2_TAPS(1), .SIGNED(1), .ROUND(1)) u_l1 (.clk(clk), .rst_n(rst_n),
                    .din_i(din[7:0]), .din_update_i(upd), .avg_clr_i(clr), .dout_o(dout_1),
                    .dout_update_o(upd_1), .dout_full_o(full_1), .fill_cnt_o(fill_1));
  ste_avg_mavg #(.DATA_W(12), .LOG2_TAPS(6), .SIGNED(0), .ROUND(1)) u_l6 (.clk(clk), .rst_n(rst_n),
                    .din_i(din[11:0]), .din_update_i(upd), .avg_clr_i(clr), .dout_o(dout_6),
                    .dout_update_o(upd_6), .dout_full_o(full_6), .fill_cnt_o(fill_6));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window-sum reference: last min(cnt, taps) samples, missing ones are zero.
  function automatic logic [31:0] mexp(input int l2, input int w, input bit s, input bit r);
    longint sum = 0;
    longint mask = (64'sd1 <<< w) - 1;
    int taps = 1 << l2;
    for (int k = 0; k < taps; k++) begin
      if (k < cnt) begin
        longint v = longint'(hist[(n - 1 - k) & 63]) & mask;
        if (s && v[w-1]) v = v - (64'sd1 <<< w);
        sum += v;
      end
    end
    if (r) sum += taps / 2;
    sum = sum >>> l2;
    return 32'(sum & mask);
  endfunction

  function automatic logic [31:0] mfill(input int l2);
    return (cnt < (1 << l2)) ? 32'(cnt) : 32'(1 << l2);
  endfunction

  task automatic strobe(input logic [15:0] d, input bit c);
    @(negedge clk);
    din = d; upd = 1'b1; clr = c;
    @(posedge clk); #1;
    upd = 1'b0; clr = 1'b0;
    if (c) cnt = 0;
    else begin
      hist[n & 63] = int'(d);
      n++;
      cnt++;
    end
    exp_upd = !c;
  endtask

  task automatic idle();
    @(negedge clk);
    upd = 1'b0; clr = 1'b0;
    @(posedge clk); #1;
    exp_upd = 1'b0;
  endtask

  task automatic model_check();
    chk("rand_dout_l3", 32'(dout_d), mexp(3, 16, 1'b0, 1'b0));
    chk("rand_fill_l3", 32'(fill_d), mfill(3));
    chk("rand_upd_l3", 32'(upd_d), 32'(exp_upd));
    chk("rand_dout_l1", 32'(dout_1), mexp(1, 8, 1'b1, 1'b1));
    chk("rand_fill_l1", 32'(fill_1), mfill(1));
    chk("rand_dout_l6", 32'(dout_6), mexp(6, 12, 1'b0, 1'b1));
    chk("rand_fill_l6", 32'(fill_6), mfill(6));
    chk("rand_full_l6", 32'(full_6), 32'(mfill(6) == 64));
  endtask

  initial begin
    rst_n = 1'b0; din = '0; upd = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", 32'(dout_d), 0);
    chk("rst_upd", 32'(upd_d), 0);
    chk("rst_full", 32'(full_d), 0);
    chk("rst_fill", 32'(fill_d), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      strobe(16'd16, 1'b0);
      chk("fill_dout", 32'(dout_d), 32'(2 * (i + 1)));
      chk("fill_cnt", 32'(fill_d), 32'(i + 1));
      chk("fill_full", 32'(full_d), 32'(i == 7));
      chk("fill_upd", 32'(upd_d), 1);
    end
    idle();
    chk("idle_upd", 32'(upd_d), 0);
    chk("idle_hold", 32'(dout_d), 16);

    for (int i = 0; i < 8; i++) begin
      strobe(16'd0, 1'b0);
      chk("wrap_dout", 32'(dout_d), 32'(14 - 2 * i));
      chk("wrap_full", 32'(full_d), 1);
    end

    strobe(16'd0, 1'b1);
    chk("clr_dout", 32'(dout_d), 0);
    chk("clr_fill", 32'(fill_d), 0);
    chk("clr_upd", 32'(upd_d), 0);
    repeat (4) strobe(16'd1, 1'b0);
    chk("trunc_4x1", 32'(dout_d), 0);
    chk("round_4x1", 32'(dout_r), 1);

    strobe(16'd0, 1'b1);
    strobe(16'hFFFF, 1'b0);
    chk("signed_m1_trunc", 32'(dout_s), 32'h0000_FFFF);
    chk("signed_m1_round", 32'(dout_sr), 0);

    strobe(16'd0, 1'b1);
    repeat (8) strobe(16'hFFFF, 1'b0);
    chk("umax", 32'(dout_d), 32'h0000_FFFF);
    chk("umax_round", 32'(dout_r), 32'h0000_FFFF);

    strobe(16'd0, 1'b1);
    repeat (8) strobe(16'h8000, 1'b0);
    chk("smin", 32'(dout_s), 32'h0000_8000);
    chk("smin_round", 32'(dout_sr), 32'h0000_8000);
    repeat (8) strobe(16'h7FFF, 1'b0);
    chk("smax", 32'(dout_s), 32'h0000_7FFF);
    chk("smax_round", 32'(dout_sr), 32'h0000_7FFF);

    strobe(16'd0, 1'b1);
    repeat (5) strobe(16'd80, 1'b0);
    chk("pre_collide", 32'(dout_d), 50);
    strobe(16'd40, 1'b1);
    chk("collide_dout", 32'(dout_d), 0);
    chk("collide_upd", 32'(upd_d), 0);
    chk("collide_fill", 32'(fill_d), 0);
    strobe(16'd8, 1'b0);
    chk("post_collide", 32'(dout_d), 1);

    repeat (3) strobe(16'd5, 1'b0);
    chk("pre_reset", 32'(dout_d), 2);
    @(negedge clk);
    din = 16'd5; upd = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_dout", 32'(dout_d), 0);
    chk("async_rst_upd", 32'(upd_d), 0);
    chk("async_rst_full", 32'(full_d), 0);
    chk("async_rst_fill", 32'(fill_d), 0);
    cnt = 0;
    @(negedge clk);
    upd = 1'b0; rst_n = 1'b1;
    strobe(16'd24, 1'b0);
    chk("post_reset", 32'(dout_d), 3);

    strobe(16'd0, 1'b1);
    for (int it = 0; it < 500; it++) begin
      int r;
      r = int'($urandom_range(0, 29));
      if (r == 0)
        strobe(16'($urandom), 1'b1);
      else if (r < 6)
        idle();
      else
        strobe(16'($urandom), 1'b0);
      model_check();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ste_avg_mavg.md
Name: ste_avg_mavg

Overview:
Parametrised moving-average filter, next generation of the fixed 8-tap averager in the ste datapath.
- Window depth is a power of two set by parameter.
- Signed or unsigned data, with optional round-to-nearest.
- Uses a running-sum accumulator over a circular sample buffer instead of an N-input adder tree.
- Reports window fill status so downstream logic knows when the average is fully settled.

Parameters:
DATA_W, 16, sample and output width in bits (2..32)
LOG2_TAPS, 3, log2 of window depth; TAPS = 2**LOG2_TAPS (1..10)
SIGNED, 0, 1 = two's-complement samples and arithmetic shift; 0 = unsigned
ROUND, 0, 1 = add 2**(LOG2_TAPS-1) before the shift (round half toward +inf); 0 = truncate

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous, active-low reset
din_i  input  DATA_W  input sample
din_update_i  input  1  sample strobe, one sample per high cycle
avg_clr_i  input  1  synchronous clear of window, accumulator and output
dout_o  output  DATA_W  current window average
dout_update_o  output  1  single-cycle pulse, dout_o refreshed
dout_full_o  output  1  window holds TAPS valid samples
fill_cnt_o  output  LOG2_TAPS+1  number of valid samples in window, saturates at TAPS

Behaviour:
- Reset: dout_o=0, dout_update_o=0, dout_full_o=0, fill_cnt_o=0; accumulator=0, write pointer=0. Buffer contents are don't-care.
- State:
  - buffer mem[TAPS] of DATA_W
  - wr_ptr of LOG2_TAPS bits, wraps TAPS-1 -> 0
  - acc of DATA_W+LOG2_TAPS bits, sign-extended when SIGNED=1
  - fill_cnt
- oldest = mem[wr_ptr] when fill_cnt==TAPS, else 0. The buffer therefore never needs clearing.
- acc_next = acc + ext(din_i) - ext(oldest). This is always representable in the acc width; no overflow is possible.
- Cycle with din_update_i=1 and avg_clr_i=0:
  - mem[wr_ptr] <= din_i; wr_ptr++; acc <= acc_next
  - fill_cnt <= min(fill_cnt+1, TAPS)
  - dout_o <= (acc_next + rnd) >> LOG2_TAPS, truncated to DATA_W. rnd = ROUND ? 2**(LOG2_TAPS-1) : 0. The shift is arithmetic when SIGNED=1.
  - dout_update_o=1 in the following cycle.
- Latency: one clock from strobe to dout_o/dout_update_o.
- Warm-up: missing samples count as zero (divide by TAPS regardless of fill).
- Equivalence: with SIGNED=0, ROUND=0, LOG2_TAPS=3, the output sequence is bit-identical to the legacy 8-tap averager.
- Cycles with din_update_i=0: all state holds; dout_update_o=0.
- avg_clr_i=1 (priority over din_update_i):
  - acc, wr_ptr, fill_cnt and dout_o go to 0; dout_update_o=0 next cycle.
  - A simultaneous sample is discarded.
- Back-to-back strobes (every cycle) are fully supported, with no stall.
- dout_full_o = (fill_cnt==TAPS); it rises in the same cycle as the dout_update_o pulse carrying the TAPS-th sample.
- Asynchronous reset mid-stream returns everything to reset values immediately. The first post-reset output reflects only post-reset samples.
- Rounding cannot overflow DATA_W in either signedness.

Decomposition:
- Package ste_avg_pkg:
  - function for the acc width (DATA_W+LOG2_TAPS)
  - rounding-constant function
  - sign/zero extend helper parameterised by SIGNED
- Sub-module ste_avg_ring contains:
  - the TAPS-deep circular buffer with wr_ptr and saturating fill_cnt
  - write enable, oldest-read output and clear input
- The buffer is kept RAM-inferable: read-before-write at the same address, no reset on the storage array.

Test Plan:
1. Defaults (16/3/0/0): reset, then 8 strobes of 16 -> dout_o = 2,4,6,8,10,12,14,16; fill_cnt_o 1..8; dout_full_o rises with the pulse carrying 16.
2. Wrap: continue with 8 strobes of 0 -> dout_o = 14,12,...,2,0; dout_full_o stays 1; wr_ptr wraps without glitch.
3. Rounding: ROUND=1 vs 0, 4 strobes of 1 -> final dout_o 1 vs 0. SIGNED=1, one strobe of 0xFFFF (-1) -> 0xFFFF with ROUND=0, 0x0000 with ROUND=1.
4. Extremes: unsigned 8x 0xFFFF -> 0xFFFF. Signed 8x 0x8000 -> 0x8000, then 8x 0x7FFF -> last 0x7FFF. No overflow.
5. Clear collision: after 5 strobes of 80, assert avg_clr_i together with a strobe of 40 -> dout_o=0, no pulse, fill_cnt_o=0. Next strobe of 8 -> dout_o=1.
6. Reset mid-stream and random regression:
   - rst_n low during continuous strobes -> all outputs 0 asynchronously.
   - Random streams with random gaps and clears for LOG2_TAPS in {1,3,6} -> match a reference-model window sum every update.
